// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES engine request arbiter.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    // Width of each per-requester packet counter (AES_ARB_STATS_EN builds)
    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: searches req starting at ptr,
// wrapping modulo NUM_REQ, and returns the first set index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] rot;

    // Rotate so that bit 0 is the requester at ptr; wrap comes from the doubled vector
    assign rot = NUM_REQ'({req, req} >> ptr);

    // Scan from the far end so the lowest rotated position wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream AES engine
// between NUM_REQ requesters. A grant spans the whole request packet and the
// engine's whole response packet, so pairs never interleave.
// Optional feature macro: AES_ARB_STATS_EN (per-requester response-packet counters).
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ*DATA_W-1:0]   req_tdata,
    input  logic [NUM_REQ-1:0]          req_tvalid,
    input  logic [NUM_REQ-1:0]          req_tlast,
    output logic [NUM_REQ-1:0]          req_tready,
    output logic [DATA_W-1:0]           aes_tdata,
    output logic                        aes_tvalid,
    output logic                        aes_tlast,
    input  logic                        aes_tready,
    input  logic [DATA_W-1:0]           rsp_tdata,
    input  logic                        rsp_tvalid,
    input  logic                        rsp_tlast,
    output logic                        rsp_tready,
    output logic [DATA_W-1:0]           out_tdata,
    output logic [NUM_REQ-1:0]          out_tvalid,
    output logic                        out_tlast,
    input  logic [NUM_REQ-1:0]          out_tready,
    output logic [ID_W-1:0]             grant_id,
`ifdef AES_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]   stat_pkts,
`endif
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t                       state_q;
    logic [IDX_W-1:0]                 grant_q;
    logic [IDX_W-1:0]                 rr_ptr_q;
    logic [IDX_W-1:0]                 pick_idx;
    logic                             pick_found;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_a;
    logic                             req_done;
    logic                             rsp_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_tvalid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign req_data_a = req_tdata;
    assign aes_tdata  = req_data_a[grant_q];
    assign out_tdata  = rsp_tdata;
    assign out_tlast  = rsp_tlast;
    assign grant_id   = ID_W'(grant_q);
    assign busy       = (state_q != IDLE);

    // Handshake routing: only the granted lane ever sees ready/valid
    always_comb begin
        req_tready = '0;
        aes_tvalid = 1'b0;
        aes_tlast  = 1'b0;
        rsp_tready = 1'b0;
        out_tvalid = '0;
        case (state_q)
            REQ: begin
                aes_tvalid          = req_tvalid[grant_q];
                aes_tlast           = req_tlast[grant_q];
                req_tready[grant_q] = aes_tready;
            end
            RSP: begin
                rsp_tready          = out_tready[grant_q];
                out_tvalid[grant_q] = rsp_tvalid;
            end
            default: ;
        endcase
    end

    assign req_done = (state_q == REQ) && aes_tvalid && aes_tready && aes_tlast;
    assign rsp_done = (state_q == RSP) && rsp_tvalid && rsp_tready && rsp_tlast;

    // Arbitration FSM: grant in IDLE, hold through request and response packets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (pick_found) begin
                    grant_q <= pick_idx;
                    state_q <= REQ;
                end
                REQ: if (req_done) state_q <= RSP;
                RSP: if (rsp_done) begin
                    rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

    // Saturating count of completed response packets per requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else if (rsp_done && (stat_q[grant_q] != {STAT_W{1'b1}})) begin
            stat_q[grant_q] <= stat_q[grant_q] + STAT_W'(1);
        end
    end

    assign stat_pkts = stat_q;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter: stimulus pushes expected beats into
// queues, a negedge monitor pops and compares on every handshake.
module tb_aes_req_arbiter;
    import aes_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 3;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*DW-1:0]  req_tdata = '0;
    logic [NR-1:0]     req_tvalid = '0;
    logic [NR-1:0]     req_tlast = '0;
    logic [NR-1:0]     req_tready;
    logic [DW-1:0]     aes_tdata;
    logic              aes_tvalid, aes_tlast;
    logic              aes_tready = 1'b0;
    logic [DW-1:0]     rsp_tdata = '0;
    logic              rsp_tvalid = 1'b0;
    logic              rsp_tlast = 1'b0;
    logic              rsp_tready;
    logic [DW-1:0]     out_tdata;
    logic [NR-1:0]     out_tvalid;
    logic              out_tlast;
    logic [NR-1:0]     out_tready = '1;
    logic [IW-1:0]     grant_id;
    logic              busy;
`ifdef AES_ARB_STATS_EN
    logic [NR*STAT_W-1:0] stat_pkts;
`endif

    aes_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .reset(rst),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast), .req_tready(req_tready),
        .aes_tdata(aes_tdata), .aes_tvalid(aes_tvalid), .aes_tlast(aes_tlast), .aes_tready(aes_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tlast(rsp_tlast), .rsp_tready(rsp_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .grant_id(grant_id),
`ifdef AES_ARB_STATS_EN
        .stat_pkts(stat_pkts),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW:0] rq [NR][$];    // requester beat queues {last, data}
    logic [DW:0] rspq[$];       // engine response beats {last, data}
    exp_t        aexp[$];       // expected beats on the engine side, in order
    exp_t        oexp[$];       // expected response beats toward requesters
    logic [NR-1:0] hs_req = '0;
    logic          hs_rsp = 1'b0;
    logic          in_rsp = 1'b0;
    logic          slow = 1'b0;
    logic          rdy_force = 1'b1;
    int            slow_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdat(input int id, input int pkt, input int b);
        return {8'(id), 8'(pkt), 16'(b)};
    endfunction

    function automatic logic [DW-1:0] sdat(input int id, input int pkt, input int b);
        return {8'hA0 | 8'(id), 8'(pkt), 16'(b)};
    endfunction

    // Queue a request packet on requester id
    task automatic req_pkt(input int id, input int pkt, input int n);
        for (int b = 0; b < n; b++) rq[id].push_back({(b == n - 1), rdat(id, pkt, b)});
    endtask

    // Expect that packet on the engine side, granted to id
    task automatic exp_req(input int id, input int pkt, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.id = IW'(id); e.data = rdat(id, pkt, b); e.last = (b == n - 1);
            aexp.push_back(e);
        end
    endtask

    // Engine response packet destined for requester id
    task automatic rsp_pkt(input int id, input int pkt, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            rspq.push_back({(b == n - 1), sdat(id, pkt, b)});
            e.id = IW'(id); e.data = sdat(id, pkt, b); e.last = (b == n - 1);
            oexp.push_back(e);
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = (rspq.size() == 0) && (aexp.size() == 0) && (oexp.size() == 0);
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, {63'd0, all_empty() && !busy}, 64'd1);
    endtask

    // Input driver: advance queues on observed handshakes, drive just after the edge
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            req_tvalid = '0;
            req_tlast  = '0;
            rsp_tvalid = 1'b0;
            rsp_tlast  = 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (hs_req[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_tvalid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) begin
                    req_tdata[i*DW +: DW] = rq[i][0][DW-1:0];
                    req_tlast[i]          = rq[i][0][DW];
                end else begin
                    req_tlast[i] = 1'b0;
                end
            end
            if (hs_rsp && rspq.size() > 0) void'(rspq.pop_front());
            rsp_tvalid = (rspq.size() > 0);
            if (rspq.size() > 0) begin
                rsp_tdata = rspq[0][DW-1:0];
                rsp_tlast = rspq[0][DW];
            end else begin
                rsp_tlast = 1'b0;
            end
            if (slow) begin
                aes_tready = (slow_cnt == 0);
                slow_cnt   = (slow_cnt == 8) ? 0 : slow_cnt + 1;
            end else begin
                aes_tready = rdy_force;
            end
        end
    end

    // Monitor: compare every handshake against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            hs_req = '0;
            hs_rsp = 1'b0;
            in_rsp = 1'b0;
        end else begin
            hs_req = req_tvalid & req_tready;
            hs_rsp = rsp_tvalid & rsp_tready;
            if (|req_tready) begin
                if (aexp.size() > 0)
                    chk("req_tready_grant", 64'(req_tready), aes_tready ? 64'(NR'(1) << aexp[0].id) : 64'd0);
                else
                    chk("req_tready_idle", 64'(req_tready), 64'd0);
            end
            if (rsp_tvalid && !in_rsp) chk("rsp_tready_outside_rsp", 64'(rsp_tready), 64'd0);
            if (aes_tvalid && aes_tready) begin
                if (aexp.size() == 0) begin
                    chk("aes_unexpected_beat", 64'(aes_tdata), 64'hDEAD);
                end else begin
                    chk("aes_tdata", 64'(aes_tdata), 64'(aexp[0].data));
                    chk("aes_tlast", 64'(aes_tlast), 64'(aexp[0].last));
                    chk("grant_id", 64'(grant_id), 64'(aexp[0].id));
                    void'(aexp.pop_front());
                end
                if (aes_tlast) in_rsp = 1'b1;
            end
            if (hs_rsp) begin
                if (oexp.size() == 0) begin
                    chk("rsp_unexpected_beat", 64'(rsp_tdata), 64'hDEAD);
                end else begin
                    chk("out_tvalid", 64'(out_tvalid), 64'(NR'(1) << oexp[0].id));
                    chk("out_tdata", 64'(out_tdata), 64'(oexp[0].data));
                    chk("out_tlast", 64'(out_tlast), 64'(oexp[0].last));
                    chk("busy_in_rsp", 64'(busy), 64'd1);
                    void'(oexp.pop_front());
                end
                if (rsp_tlast) in_rsp = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_ready_valid", {req_tready, out_tvalid, aes_tvalid, rsp_tready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single requester 1, 5-beat request, 4-beat response
        rsp_pkt(1, 1, 4);
        exp_req(1, 1, 5);
        req_pkt(1, 1, 5);
        wait_done("t1", 200);

        // 2: requesters 0,2,3 at once from rr_ptr=0 -> order 0,2,3
        do_reset();
        rsp_pkt(0, 2, 2); rsp_pkt(2, 2, 2); rsp_pkt(3, 2, 2);
        exp_req(0, 2, 3); exp_req(2, 2, 2); exp_req(3, 2, 1);
        req_pkt(0, 2, 3); req_pkt(2, 2, 2); req_pkt(3, 2, 1);
        wait_done("t2", 300);
        // pointer wrapped to 0: requester 0 beats requester 3
        rsp_pkt(0, 3, 1); rsp_pkt(3, 3, 1);
        exp_req(0, 3, 1); exp_req(3, 3, 2);
        req_pkt(0, 3, 1); req_pkt(3, 3, 2);
        wait_done("t2_wrap", 200);

        // 3: aes_tready one high in nine
        slow = 1'b1; slow_cnt = 0;
        rsp_pkt(2, 4, 2);
        exp_req(2, 4, 4);
        req_pkt(2, 4, 4);
        wait_done("t3", 600);
        slow = 1'b0;

        // 4: response offered while the request is stalled in REQ
        rdy_force = 1'b0;
        rsp_pkt(3, 5, 3);
        exp_req(3, 5, 3);
        req_pkt(3, 5, 3);
        repeat (6) @(posedge clk);
        rdy_force = 1'b1;
        wait_done("t4", 200);

        // 5: reset while requester 2 is mid-REQ
        rdy_force = 1'b0;
        req_pkt(2, 6, 5);
        repeat (4) @(posedge clk);
        chk("t5_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_grant", 64'(grant_id), 64'd0);
        chk("t5_ready_valid", {req_tready, out_tvalid, aes_tvalid, rsp_tready}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_force = 1'b1;
        rsp_pkt(0, 7, 1);
        exp_req(0, 7, 2);
        req_pkt(0, 7, 2);
        wait_done("t5_after", 200);

`ifdef AES_ARB_STATS_EN
        // 6: three packets from requester 1 counted
        do_reset();
        for (int p = 0; p < 3; p++) begin
            rsp_pkt(1, 8 + p, 1);
            exp_req(1, 8 + p, 1);
            req_pkt(1, 8 + p, 1);
            wait_done("t6", 100);
        end
        chk("stat_req1", 64'(stat_pkts[31:16]), 64'd3);
        chk("stat_others", 64'({stat_pkts[63:32], stat_pkts[15:0]}), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
